ex_operand_stage: RTL and testbench
===================================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width.
REQ-002 Parameter REG_AW, default 5, register-address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 stall  in  1  hold all ID/EX state this cycle.
REQ-006 flush  in  1  load a bubble this cycle.
REQ-007 id_valid  in  1  ID stage presents a real instruction.
REQ-008 id_rs, id_rt, id_rd  in  REG_AW each  source and destination register numbers.
REQ-009 id_rd1, id_rd2  in  DATA_W each  register-file read data for rs, rt.
REQ-010 id_imm  in  DATA_W  sign-extended immediate.
REQ-011 id_alu_op  in  3  ALU code: 010 add, 110 sub, 000 and, 001 or, 100 not, 111 slt.
REQ-012 id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  decoded controls.
REQ-013 mem_reg_write  in  1, mem_wreg  in  REG_AW, mem_result  in  DATA_W  EX/MEM forwarding source.
REQ-014 wb_reg_write  in  1, wb_wreg  in  REG_AW, wb_result  in  DATA_W  MEM/WB forwarding source.
REQ-015 ex_valid  out  1  EX stage holds a real instruction.
REQ-016 alu_a, alu_b  out  DATA_W each  ALU operands.
REQ-017 alu_op  out  3  ALU code, passed through unchanged.
REQ-018 ex_store_data  out  DATA_W  forwarded rt value for stores.
REQ-019 ex_wreg  out  REG_AW  destination register (rd if reg_dst=1, else rt).
REQ-020 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered controls.
REQ-021 load_use_stall  out  1  request to freeze PC and IF/ID.

Function
REQ-022 ID/EX register SHALL capture all id_* inputs on each rising edge when stall=0 and flush=0; latency ID to EX outputs is exactly one cycle.
REQ-023 flush=1 SHALL override stall: next state is valid=0 with all controls 0; data fields don't-care.
REQ-024 stall=1, flush=0 SHALL hold every registered field unchanged.
REQ-025 id_valid=0 at capture SHALL register valid=0 and all controls 0.
REQ-026 ex_reg_write, ex_mem_read, ex_mem_write SHALL be 0 whenever ex_valid=0.
REQ-027 ex_wreg SHALL be selected at capture (id_reg_dst ? id_rd : id_rt).
REQ-028 Forwarded rs/rt SHALL be combinational from the registered rs/rt number and value: EX/MEM match (mem_reg_write=1, mem_wreg==reg, reg!=0) first, else MEM/WB match (wb_reg_write=1, wb_wreg==reg, reg!=0), else registered regfile value.
REQ-029 Register 0 SHALL never be forwarded; the registered value passes through.
REQ-030 alu_a SHALL equal forwarded rs; alu_b SHALL equal registered imm if alu_src=1, else forwarded rt; ex_store_data SHALL always equal forwarded rt.
REQ-031 Forwarding SHALL be re-evaluated every cycle, including while stalled.
REQ-032 load_use_stall SHALL be 1 iff ex_valid=1, ex_mem_read=1, ex_wreg!=0, id_valid=1, and ex_wreg equals id_rs or id_rt; combinational, no added latency.
REQ-033 Pipeline control SHALL respond to load_use_stall by flushing this stage next edge; this stage does not self-flush.

Reset
REQ-034 rst_n=0 SHALL immediately clear ex_valid, all control outputs, ex_wreg, alu_op, and all registered data to 0, independent of clk.
REQ-035 Reset SHALL override stall and flush; first capture occurs on the first rising edge after rst_n deasserts.

Structure
REQ-036 ALU op codes and forward-select encoding (NONE, EXMEM, MEMWB) SHALL live in a shared package used by the ALU and its decoder.
REQ-037 One sub-module, fwd_mux, SHALL implement REQ-028/029 and be instantiated twice (rs, rt).

Verification
REQ-038 Reset mid-run: rst_n low asynchronously between edges -> ex_valid=0, alu_a=0 and all controls 0 before the next edge.
REQ-039 Forward priority: rs=5, mem_wreg=5 with mem_result=0x11, wb_wreg=5 with wb_result=0x22 -> alu_a=0x11; drop mem_reg_write -> alu_a=0x22.
REQ-040 Register zero: rs=0, id_rd1=0, mem_wreg=0, mem_reg_write=1, mem_result=0xFF -> alu_a=0.
REQ-041 Load-use: EX holds lw to r8; ID rt=8 -> load_use_stall=1; same with ex_wreg=0 -> 0.
REQ-042 Stall vs flush: stall=1 holds alu_op=110 over 3 cycles; stall=1 with flush=1 -> ex_valid=0, ex_mem_write=0 next edge.
REQ-043 Immediate path: alu_src=1, imm=0xFFFFFFFC, rt forwarded=0x7 -> alu_b=0xFFFFFFFC, ex_store_data=0x7.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// Shared encodings for the EX operand stage: ALU op codes, forward-select
// encoding and the registered control bundle.
package ex_operand_stage_pkg;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_NOT = 3'b100,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_NONE  = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_e;

   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic alu_src;
   } ex_ctrl_t;

   // A bubble carries no side-effecting controls, whatever ID decoded.
   function automatic ex_ctrl_t gate_ctrl(input ex_ctrl_t c);
      ex_ctrl_t r;
      r = c.valid ? c : '0;
      return r;
   endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Operand forwarding mux: newest producer (EX/MEM) wins over MEM/WB;
// register zero is hardwired and never forwarded.
module fwd_mux
   import ex_operand_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] reg_num,
   input  logic [DATA_W-1:0] reg_val,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_wreg,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_wreg,
   input  logic [DATA_W-1:0] wb_result,
   output logic [DATA_W-1:0] fwd_val
);

   fwd_sel_e sel;

   always_comb begin
      sel = FWD_NONE;
      if (reg_num != '0) begin
         if (mem_reg_write && (mem_wreg == reg_num)) begin
            sel = FWD_EXMEM;
         end else if (wb_reg_write && (wb_wreg == reg_num)) begin
            sel = FWD_MEMWB;
         end
      end
   end

   always_comb begin
      fwd_val = reg_val;
      case (sel)
         FWD_EXMEM: fwd_val = mem_result;
         FWD_MEMWB: fwd_val = wb_result;
         default:   fwd_val = reg_val;
      endcase
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detect.
// Flush beats stall; reset beats both.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [2:0]        id_alu_op,
   input  logic              id_alu_src,
   input  logic              id_reg_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_wreg,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_wreg,
   input  logic [DATA_W-1:0] wb_result,
   output logic              ex_valid,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_op,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_AW-1:0] ex_wreg,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg,
   output logic              load_use_stall
);

   ex_ctrl_t          ctrl_d;
   ex_ctrl_t          ctrl_q;
   logic [REG_AW-1:0] rs_q;
   logic [REG_AW-1:0] rt_q;
   logic [REG_AW-1:0] wreg_q;
   logic [2:0]        alu_op_q;
   logic [DATA_W-1:0] rd1_q;
   logic [DATA_W-1:0] rd2_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] rs_fwd;
   logic [DATA_W-1:0] rt_fwd;

   always_comb begin
      ctrl_d            = '0;
      ctrl_d.valid      = id_valid & ~flush;
      ctrl_d.reg_write  = id_reg_write;
      ctrl_d.mem_read   = id_mem_read;
      ctrl_d.mem_write  = id_mem_write;
      ctrl_d.mem_to_reg = id_mem_to_reg;
      ctrl_d.alu_src    = id_alu_src;
      ctrl_d            = gate_ctrl(ctrl_d);
   end

   // Data fields are loaded on flush too; they are meaningless under valid=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q   <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         wreg_q   <= '0;
         alu_op_q <= '0;
         rd1_q    <= '0;
         rd2_q    <= '0;
         imm_q    <= '0;
      end else if (flush || !stall) begin
         ctrl_q   <= ctrl_d;
         rs_q     <= id_rs;
         rt_q     <= id_rt;
         wreg_q   <= id_reg_dst ? id_rd : id_rt;
         alu_op_q <= id_alu_op;
         rd1_q    <= id_rd1;
         rd2_q    <= id_rd2;
         imm_q    <= id_imm;
      end
   end

   fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
      .reg_num       (rs_q),
      .reg_val       (rd1_q),
      .mem_reg_write (mem_reg_write),
      .mem_wreg      (mem_wreg),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_wreg       (wb_wreg),
      .wb_result     (wb_result),
      .fwd_val       (rs_fwd)
   );

   fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
      .reg_num       (rt_q),
      .reg_val       (rd2_q),
      .mem_reg_write (mem_reg_write),
      .mem_wreg      (mem_wreg),
      .mem_result    (mem_result),
      .wb_reg_write  (wb_reg_write),
      .wb_wreg       (wb_wreg),
      .wb_result     (wb_result),
      .fwd_val       (rt_fwd)
   );

   assign ex_valid      = ctrl_q.valid;
   assign ex_reg_write  = ctrl_q.valid & ctrl_q.reg_write;
   assign ex_mem_read   = ctrl_q.valid & ctrl_q.mem_read;
   assign ex_mem_write  = ctrl_q.valid & ctrl_q.mem_write;
   assign ex_mem_to_reg = ctrl_q.valid & ctrl_q.mem_to_reg;
   assign ex_wreg       = wreg_q;
   assign alu_op        = alu_op_q;
   assign alu_a         = rs_fwd;
   assign alu_b         = (ctrl_q.valid & ctrl_q.alu_src) ? imm_q : rt_fwd;
   assign ex_store_data = rt_fwd;

   // A load in EX cannot feed the instruction behind it without a bubble.
   assign load_use_stall = ex_valid & ex_mem_read & (ex_wreg != '0) & id_valid &
                           ((ex_wreg == id_rs) | (ex_wreg == id_rt));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage with hand-computed expected values.
module tb_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rd1, id_rd2, id_imm;
   logic [2:0]  id_alu_op;
   logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic        mem_reg_write, wb_reg_write;
   logic [4:0]  mem_wreg, wb_wreg;
   logic [31:0] mem_result, wb_result;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [2:0]  alu_op;
   logic [4:0]  ex_wreg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_imm(id_imm), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_mem_to_reg(id_mem_to_reg), .mem_reg_write(mem_reg_write), .mem_wreg(mem_wreg),
      .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg),
      .wb_result(wb_result), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .ex_store_data(ex_store_data), .ex_wreg(ex_wreg),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .load_use_stall(load_use_stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_id();
      id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
      id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_alu_op = 3'b000;
      id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
      id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
   endtask

   task automatic clear_fwd();
      mem_reg_write = 0; mem_wreg = 0; mem_result = 0;
      wb_reg_write = 0; wb_wreg = 0; wb_result = 0;
   endtask

   initial begin
      rst_n = 0; stall = 0; flush = 0;
      clear_id();
      clear_fwd();
      #12;
      chk("rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_lus", {31'd0, load_use_stall}, 32'd0);

      // first capture after reset release; priority forwarding on rs
      rst_n = 1;
      id_valid = 1; id_rs = 5; id_rt = 6; id_rd = 9; id_rd1 = 32'hAAAA; id_rd2 = 32'hBBBB;
      id_imm = 32'h10; id_alu_op = 3'b010; id_reg_dst = 1; id_reg_write = 1;
      tick();
      chk("cap_valid", {31'd0, ex_valid}, 32'd1);
      chk("cap_wreg_rd", {27'd0, ex_wreg}, 32'd9);
      chk("cap_alu_op", {29'd0, alu_op}, 32'd2);
      chk("cap_reg_write", {31'd0, ex_reg_write}, 32'd1);
      chk("cap_alu_a", alu_a, 32'hAAAA);
      chk("cap_alu_b", alu_b, 32'hBBBB);
      clear_id();
      stall = 1;
      mem_reg_write = 1; mem_wreg = 5; mem_result = 32'h11;
      wb_reg_write = 1; wb_wreg = 5; wb_result = 32'h22;
      #1 chk("fwd_exmem_first", alu_a, 32'h11);
      mem_reg_write = 0;
      #1 chk("fwd_memwb", alu_a, 32'h22);
      wb_wreg = 6;
      #1 chk("fwd_none_rs", alu_a, 32'hAAAA);
      chk("fwd_rt_alu_b", alu_b, 32'h22);
      chk("fwd_rt_store", ex_store_data, 32'h22);
      tick();
      wb_result = 32'h33;
      #1 chk("fwd_while_stalled", alu_b, 32'h33);
      clear_fwd();
      stall = 0;

      // register zero never forwarded
      id_valid = 1; id_rs = 0; id_rd1 = 0; id_rt = 2; id_rd2 = 32'h5;
      tick();
      mem_reg_write = 1; mem_wreg = 0; mem_result = 32'hFF;
      #1 chk("r0_alu_a", alu_a, 32'd0);
      clear_fwd();

      // immediate path with forwarded rt
      id_valid = 1; id_rs = 1; id_rt = 7; id_rd2 = 32'h3; id_imm = 32'hFFFFFFFC;
      id_alu_src = 1; id_reg_dst = 0; id_rd = 12;
      tick();
      mem_reg_write = 1; mem_wreg = 7; mem_result = 32'h7;
      #1 chk("imm_alu_b", alu_b, 32'hFFFFFFFC);
      chk("imm_store", ex_store_data, 32'h7);
      chk("imm_wreg_rt", {27'd0, ex_wreg}, 32'd7);
      clear_fwd();
      clear_id();

      // load-use hazard
      id_valid = 1; id_rs = 4; id_rt = 8; id_alu_src = 1; id_mem_read = 1;
      id_reg_write = 1; id_mem_to_reg = 1; id_alu_op = 3'b010;
      tick();
      chk("lw_mem_read", {31'd0, ex_mem_read}, 32'd1);
      chk("lw_mem_to_reg", {31'd0, ex_mem_to_reg}, 32'd1);
      clear_id();
      id_valid = 1; id_rs = 3; id_rt = 8;
      #1 chk("lus_rt_hit", {31'd0, load_use_stall}, 32'd1);
      id_rs = 8; id_rt = 2;
      #1 chk("lus_rs_hit", {31'd0, load_use_stall}, 32'd1);
      id_valid = 0;
      #1 chk("lus_id_invalid", {31'd0, load_use_stall}, 32'd0);
      id_valid = 1; id_rs = 0; id_rt = 0; id_mem_read = 1; id_reg_write = 1;
      tick();
      clear_id();
      id_valid = 1; id_rs = 0; id_rt = 0;
      #1 chk("lus_wreg0", {31'd0, load_use_stall}, 32'd0);
      clear_id();

      // stall holds three cycles, then flush wins over stall
      id_valid = 1; id_alu_op = 3'b110; id_mem_write = 1; id_rs = 1; id_rt = 2;
      tick();
      chk("sw_alu_op", {29'd0, alu_op}, 32'd6);
      stall = 1; id_alu_op = 3'b010; id_mem_write = 0; id_valid = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_alu_op", {29'd0, alu_op}, 32'd6);
         chk("stall_mem_write", {31'd0, ex_mem_write}, 32'd1);
      end
      id_mem_write = 1;
      flush = 1;
      tick();
      chk("flush_valid", {31'd0, ex_valid}, 32'd0);
      chk("flush_mem_write", {31'd0, ex_mem_write}, 32'd0);
      flush = 0; stall = 0;
      clear_id();

      // id_valid=0 capture yields a bubble
      id_valid = 0; id_reg_write = 1; id_mem_read = 1;
      tick();
      chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
      chk("bubble_reg_write", {31'd0, ex_reg_write}, 32'd0);
      chk("bubble_mem_read", {31'd0, ex_mem_read}, 32'd0);

      // asynchronous reset between edges
      clear_id();
      id_valid = 1; id_rs = 4; id_rd1 = 32'h55; id_reg_write = 1; id_mem_read = 1;
      id_alu_op = 3'b111; id_reg_dst = 1; id_rd = 10;
      tick();
      chk("pre_rst_alu_a", alu_a, 32'h55);
      #2 rst_n = 0;
      #1;
      chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("async_rst_alu_a", alu_a, 32'd0);
      chk("async_rst_reg_write", {31'd0, ex_reg_write}, 32'd0);
      chk("async_rst_mem_read", {31'd0, ex_mem_read}, 32'd0);
      chk("async_rst_alu_op", {29'd0, alu_op}, 32'd0);
      chk("async_rst_wreg", {27'd0, ex_wreg}, 32'd0);
      stall = 1; flush = 1;
      tick();
      chk("rst_beats_flush", {31'd0, ex_valid}, 32'd0);
      stall = 0; flush = 0;
      #2 rst_n = 1;
      tick();
      chk("post_rst_capture", {31'd0, ex_valid}, 32'd1);
      chk("post_rst_wreg", {27'd0, ex_wreg}, 32'd10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
